// File: rtl/mul_div_unit.sv
// Iterative 8051 MUL AB / DIV AB unit: shift-add multiply and restoring divide,
// one bit per cycle. Results and the PSW flag code are presented for one cycle on done.
module mul_div_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] b_out,
    output logic             carry_out,
    output logic             overflow_out,
    output logic [1:0]       flag_set
);

    localparam int unsigned    CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST      = CW'(WIDTH - 1);
    localparam logic [1:0]     CY_OV_SET = 2'b11;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               op_q, op_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   rem_q, rem_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   bo_q, bo_d;
    logic               cy_q, cy_d;
    logic               ov_q, ov_d;
    logic [1:0]         fs_q, fs_d;

    logic               accept;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     part_rem;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_next;

    // done_q masks start so a request in the done cycle is dropped, not queued
    assign accept = (state_q == IDLE) && start && !done_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            count_q <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            acc_q   <= '0;
            bo_q    <= '0;
            cy_q    <= 1'b0;
            ov_q    <= 1'b0;
            fs_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            count_q <= count_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            acc_q   <= acc_d;
            bo_q    <= bo_d;
            cy_q    <= cy_d;
            ov_q    <= ov_d;
            fs_q    <= fs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!op_div)            state_d = MUL;
                    else if (b_in == '0)    state_d = DONE;
                    else                    state_d = DIV;
                end
            end
            MUL, DIV: if (count_q == LAST) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // MUL: A sits in prod_q's low half and shifts out LSB first as the product
    // shifts in from the top. DIV: the low half holds the dividend/quotient.
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, b_q} : '0);
    assign part_rem = {rem_q, prod_q[WIDTH-1]};
    assign q_bit    = part_rem >= {1'b0, b_q};
    assign rem_next = q_bit ? WIDTH'(part_rem - {1'b0, b_q}) : part_rem[WIDTH-1:0];

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        count_d = count_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        bo_d    = bo_q;
        cy_d    = 1'b0;
        ov_d    = ov_q;
        done_d  = (state_q == DONE);
        fs_d    = (state_q == DONE) ? CY_OV_SET : 2'b00;
        busy_d  = (state_d != IDLE) || (state_q == DONE);

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = acc_in;
                    b_d     = b_in;
                    op_d    = op_div;
                    count_d = '0;
                    prod_d  = {{WIDTH{1'b0}}, acc_in};
                    rem_d   = '0;
                end
            end
            MUL: begin
                prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
                count_d = CW'(count_q + 1'b1);
            end
            DIV: begin
                prod_d  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], q_bit};
                rem_d   = rem_next;
                count_d = CW'(count_q + 1'b1);
            end
            DONE: begin
                if (!op_q) begin
                    acc_d = prod_q[WIDTH-1:0];
                    bo_d  = prod_q[2*WIDTH-1:WIDTH];
                    ov_d  = |prod_q[2*WIDTH-1:WIDTH];
                end else if (b_q == '0) begin
                    acc_d = a_q;
                    bo_d  = b_q;
                    ov_d  = 1'b1;
                end else begin
                    acc_d = prod_q[WIDTH-1:0];
                    bo_d  = rem_q;
                    ov_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign acc_out      = acc_q;
    assign b_out        = bo_q;
    assign carry_out    = cy_q;
    assign overflow_out = ov_q;
    assign flag_set     = fs_q;

endmodule
